// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) one bit per clock, LSB first.
// Ports: clk, rst (async high), start/a/b/bin in; busy, done, diff, bout out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic             br;
  logic             br_n;
  logic             d;
  logic             last;
  logic [CW-1:0]    cnt;

  // one full-subtractor cell, reused every cycle
  assign d     = sa[0] ^ sb[0] ^ br;
  assign br_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res_n = {d, res[WIDTH-1:1]};
  assign last  = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_n;
      res <= res_n;
      cnt <= cnt + 1'b1;
      // outputs only move on the completing edge
      if (last) begin
        diff <= res_n;
        bout <= br_n;
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning the operand and difference width in bits (legal range 2..32).
REQ-002 The block SHALL provide the following ports:
  clk         input   1      single clock, all state updates on the rising edge
  rst         input   1      reset, asynchronous, active-high
  start       input   1      request to begin a subtraction; sampled on the rising edge
  a           input   WIDTH  minuend; sampled when start is accepted
  b           input   WIDTH  subtrahend; sampled when start is accepted
  bin         input   1      borrow-in; sampled when start is accepted
  busy        output  1      high while a subtraction is in progress
  done        output  1      one-cycle pulse when the result is valid
  diff        output  WIDTH  registered difference (a - b - bin) mod 2^WIDTH
  bout        output  1      registered borrow-out; 1 when a < b + bin

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-004 In IDLE, start=1 at a rising edge SHALL be accepted, which does all of the following:
  - latch a, b and bin into internal shift registers A, B and borrow flip-flop BR;
  - clear the bit counter to 0;
  - move the FSM to RUN.
REQ-005 In RUN, each rising edge SHALL process exactly one bit, LSB first:
  - d = A[0] ^ B[0] ^ BR;
  - BR <= (~A[0] & B[0]) | (~(A[0] ^ B[0]) & BR);
  - d is shifted into the MSB of an internal result register;
  - A and B shift right by one;
  - the counter increments.
REQ-006 On the edge that processes bit WIDTH-1, the FSM SHALL go to DONE, and the following SHALL be loaded on that same edge:
  - diff <= the completed result;
  - bout <= the final BR.
REQ-007 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-008 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-009 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and busy SHALL be high for exactly WIDTH cycles.
REQ-010 start SHALL be ignored in RUN and in DONE; there is no queueing, so a dropped request must be reissued in IDLE.
REQ-011 diff and bout SHALL change only on the completing edge (REQ-006) or on reset, and SHALL hold their value through IDLE and through any subsequent RUN until the next completion.
REQ-012 Changes on a, b and bin after acceptance SHALL NOT affect the result in progress.
REQ-013 Arithmetic SHALL be unsigned, modulo 2^WIDTH. For signed use, the result SHALL equal the two's-complement difference; overflow detection is out of scope.
REQ-014 The back-to-back minimum issue interval SHALL be WIDTH+2 cycles: start in the first IDLE cycle after DONE is accepted.

Reset
REQ-015 rst=1 SHALL asynchronously force the following, regardless of clk:
  - FSM = IDLE, counter = 0, BR = 0, all internal shift registers = 0;
  - busy = 0, done = 0, diff = 0, bout = 0.
REQ-016 rst asserted mid-RUN SHALL abort the operation: no done pulse, and diff/bout read 0.
REQ-017 start SHALL NOT be accepted on any edge where rst=1. The first acceptable edge SHALL be the first rising edge after rst deasserts.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios (WIDTH=8):
  - Basic: a=100, b=58, bin=0, start pulse -> busy high for 8 cycles, done pulse on the 9th cycle after the accepting edge, diff=42, bout=0.
  - Borrow: a=5, b=7, bin=0 -> diff=254, bout=1; then a=0, b=0, bin=1 -> diff=255, bout=1.
  - Equal and extremes: a=255, b=255, bin=0 -> diff=0, bout=0; a=0, b=255, bin=0 -> diff=1, bout=1; a=255, b=0, bin=1 -> diff=254, bout=0.
  - Ignored start and stable operands: start held high continuously with a, b randomised every cycle after acceptance -> result reflects only the accepted operands; the next acceptance occurs exactly WIDTH+2 cycles later.
  - Reset mid-operation: rst asserted asynchronously (between edges) at bit 4 of 100-58 -> busy, done, diff and bout go to 0 immediately; no done pulse; a new start after release yields a correct result.
  - Randomised self-check: 1000 random (a, b, bin) against the reference model (a-b-bin) mod 256 with borrow flag, including WIDTH=2 and WIDTH=32 builds.
